// File: rtl/pipe_pkg.sv
// Shared definitions for the forward/backward valid-ready register slices.
// Holds the depth ceiling and the width helper used for occupancy counters.
package pipe_pkg;

  localparam int unsigned PIPE_MAX_DEPTH = 8;

  // Bits needed to represent values 0..n-1; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/forward_pipe_stage.sv
// One registered valid/data stage of forward_pipe.
// FORWARD_PIPE_BUBBLE_COLLAPSE_EN selects per-stage ready (collapse) vs shared advance (lockstep).
module forward_pipe_stage #(
  parameter int unsigned L = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [L-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [L-1:0] out_data
);

  logic         v;
  logic [L-1:0] d;
  logic         load;

`ifdef FORWARD_PIPE_BUBBLE_COLLAPSE_EN
  // An empty stage may fill even while everything below it is stalled.
  always_comb in_ready = !v || out_ready;
`else
  // out_ready is the shared advance; all stages shift together.
  always_comb in_ready = out_ready;
`endif

  always_comb load = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      if (in_ready) v <= in_valid;
      if (load)     d <= in_data;
    end
  end

  always_comb begin
    out_valid = v;
    out_data  = d;
  end

endmodule

// File: rtl/forward_pipe.sv
// Forward register slice: DEPTH registered valid/data stages, ready passes back combinationally.
// Build option: define FORWARD_PIPE_BUBBLE_COLLAPSE_EN for bubble-collapsing stages.
module forward_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned L     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_f,
  output logic                         ready_f,
  input  logic [L-1:0]                 data_f,
  output logic                         valid_b,
  input  logic                         ready_b,
  output logic [L-1:0]                 data_b,
  output logic [clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int unsigned OW = clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
    $error("forward_pipe: DEPTH must be within 1..%0d", PIPE_MAX_DEPTH);
  end

  // Index i is the boundary feeding stage i; index DEPTH is the output boundary.
  logic [DEPTH:0] vld;
  logic [DEPTH:0] rdy;
  logic [L-1:0]   dat [DEPTH+1];
  logic           in_fire;
  logic           out_fire;

  assign vld[0] = valid_f;
  assign dat[0] = data_f;

`ifdef FORWARD_PIPE_BUBBLE_COLLAPSE_EN
  assign rdy[DEPTH] = ready_b;
`else
  assign rdy[DEPTH] = ready_b || !vld[DEPTH];
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    forward_pipe_stage #(.L(L)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld[i]),
      .in_ready  (rdy[i]),
      .in_data   (dat[i]),
      .out_valid (vld[i+1]),
      .out_ready (rdy[i+1]),
      .out_data  (dat[i+1])
    );
  end

  always_comb begin
    ready_f  = rdy[0];
    valid_b  = vld[DEPTH];
    data_b   = dat[DEPTH];
    in_fire  = valid_f && ready_f;
    out_fire = valid_b && ready_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (in_fire && !out_fire) begin
      occupancy <= occupancy + OW'(1);
    end else if (!in_fire && out_fire) begin
      occupancy <= occupancy - OW'(1);
    end
  end

endmodule

// File: tb/tb_forward_pipe.sv
// Scoreboard bench for forward_pipe: DEPTH=2 instance for streaming/stall/reset/random,
// DEPTH=4 instance for the bubble behaviour of the selected build.
module tb_forward_pipe;

  localparam int unsigned D  = 2;
  localparam int unsigned D4 = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  always #5 clk = ~clk;

  logic       valid_f, ready_f, valid_b, ready_b;
  logic [7:0] data_f, data_b;
  logic [1:0] occupancy;

  logic       v4_f, r4_f, v4_b, r4_b;
  logic [7:0] d4_f, d4_b;
  logic [2:0] occ4;

  forward_pipe #(.L(8), .DEPTH(D)) u_dut (
    .clk(clk), .rst(rst),
    .valid_f(valid_f), .ready_f(ready_f), .data_f(data_f),
    .valid_b(valid_b), .ready_b(ready_b), .data_b(data_b),
    .occupancy(occupancy)
  );

  forward_pipe #(.L(8), .DEPTH(D4)) u_dut4 (
    .clk(clk), .rst(rst),
    .valid_f(v4_f), .ready_f(r4_f), .data_f(d4_f),
    .valid_b(v4_b), .ready_b(r4_b), .data_b(d4_b),
    .occupancy(occ4)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  exp_q [$];
  int          model_occ = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected beats recorded as the producer hands them over.
  always @(negedge clk) begin
    if (rst && valid_f && ready_f) exp_q.push_back(data_f);
  end

  // Output monitor: reset values, occupancy model, ready rules, stall stability, beat order.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_valid_b", valid_b, 1'b0);
      check("rst_data_b", data_b, 8'h00);
      check("rst_occupancy", occupancy, 2'd0);
      check("rst_ready_f", ready_f, 1'b1);
      exp_q.delete();
      model_occ  = 0;
      prev_stall = 1'b0;
    end else begin
      check("occupancy", occupancy, model_occ);
      if (model_occ == 0) check("ready_f_empty", ready_f, 1'b1);
      if (model_occ == D && !ready_b) check("ready_f_full_stall", ready_f, 1'b0);
`ifdef FORWARD_PIPE_BUBBLE_COLLAPSE_EN
      check("ready_f_collapse", ready_f, (model_occ < D) || ready_b);
`endif
      if (prev_stall) begin
        check("stall_valid_b", valid_b, 1'b1);
        check("stall_data_b", data_b, prev_data);
      end
      if (valid_b && ready_b) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no beat at %0t", data_b, $time);
        end else begin
          check("beat_data", data_b, exp_q.pop_front());
        end
      end
      model_occ  = model_occ + int'(valid_f && ready_f) - int'(valid_b && ready_b);
      prev_stall = valid_b && !ready_b;
      prev_data  = data_b;
    end
  end

  initial begin
    valid_f = 1'b1; data_f = 8'hA5; ready_b = 1'b0;
    v4_f = 1'b0; d4_f = 8'h00; r4_b = 1'b0;

    // Reset with a valid beat offered
    repeat (3) step();
    check("t1_ready_f", ready_f, 1'b1);
    check("t1_valid_b", valid_b, 1'b0);
    check("t1_data_b", data_b, 8'h00);
    check("t1_occupancy", occupancy, 2'd0);
    rst = 1'b1; valid_f = 1'b0;
    step();
    check("t1_nothing_captured", valid_b, 1'b0);
    check("t1_occ_after", occupancy, 2'd0);

    // Streaming 01..10 with downstream always ready
    ready_b = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      valid_f = 1'b1;
      data_f  = 8'(i);
      step();
      if (i == 1) check("t2_first_latency", valid_b, 1'b0);
      if (i == 2) begin
        check("t2_first_valid", valid_b, 1'b1);
        check("t2_first_data", data_b, 8'h01);
      end
      if (i >= 2) check("t2_occ", occupancy, 2'd2);
    end
    valid_f = 1'b0;
    repeat (3) step();
    check("t2_drained", occupancy, 2'd0);

    // Stall with two beats held
    ready_b = 1'b0;
    valid_f = 1'b1; data_f = 8'h11; step();
    data_f = 8'h22; step();
    valid_f = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("t3_ready_f", ready_f, 1'b0);
      check("t3_data_b", data_b, 8'h11);
      check("t3_occ", occupancy, 2'd2);
      step();
    end
    ready_b = 1'b1;
    step();
    check("t3_second_valid", valid_b, 1'b1);
    check("t3_second_data", data_b, 8'h22);
    step();
    check("t3_empty_valid", valid_b, 1'b0);
    check("t3_empty_occ", occupancy, 2'd0);

    // Bubble behaviour on the DEPTH=4 instance
    r4_b = 1'b0;
    v4_f = 1'b1; d4_f = 8'h5A; step();
`ifdef FORWARD_PIPE_BUBBLE_COLLAPSE_EN
    for (int k = 0; k < 3; k++) begin
      check("t4_collapse_ready", r4_f, 1'b1);
      d4_f = 8'(8'h5B + k);
      step();
    end
    v4_f = 1'b0;
    check("t4_collapse_occ", occ4, 3'd4);
    check("t4_collapse_full", r4_f, 1'b0);
    check("t4_collapse_data", d4_b, 8'h5A);
`else
    v4_f = 1'b0;
    repeat (3) step();
    check("t4_lockstep_valid", v4_b, 1'b1);
    check("t4_lockstep_data", d4_b, 8'h5A);
    check("t4_lockstep_ready", r4_f, 1'b0);
    check("t4_lockstep_occ", occ4, 3'd1);
`endif
    r4_b = 1'b1;
    repeat (6) step();
    check("t4_drained_occ", occ4, 3'd0);
    check("t4_drained_valid", v4_b, 1'b0);

    // Mid-stream reset discards in-flight beats
    ready_b = 1'b0;
    valid_f = 1'b1; data_f = 8'h77; step();
    data_f = 8'h88; step();
    valid_f = 1'b0;
    check("t5_occ_before", occupancy, 2'd2);
    rst = 1'b0;
    #1;
    check("t5_rst_valid_b", valid_b, 1'b0);
    check("t5_rst_data_b", data_b, 8'h00);
    check("t5_rst_occ", occupancy, 2'd0);
    check("t5_rst_ready_f", ready_f, 1'b1);
    step();
    rst = 1'b1; ready_b = 1'b1;
    repeat (4) step();
    check("t5_no_old_beat", valid_b, 1'b0);
    check("t5_occ_after", occupancy, 2'd0);

    // Random traffic at 50% on both sides
    for (int c = 0; c < 10000; c++) begin
      valid_f = 1'($urandom_range(0, 1));
      data_f  = 8'($urandom);
      ready_b = 1'($urandom_range(0, 1));
      step();
    end
    valid_f = 1'b0; ready_b = 1'b1;
    repeat (5) step();
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_final_occ", occupancy, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
